// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Constants shared between the cpu core and its output-side
//             stages: the datapath word width and the OUT opcode that the
//             decode stage recognises when generating the port write strobe.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Datapath word width; port words match it.
    localparam int WORD_W = 16;

    // Opcode of the OUT instruction as seen by the decode stage.
    localparam logic [3:0] c_OP_OUT = 4'hE;

    // Decode helper: true when the opcode drives an out_port write.
    function automatic logic is_out_op(input logic [3:0] opcode);
        return (opcode == c_OP_OUT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_port_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_buffer_if
//  Purpose  : Bundles the core-side write path and the consumer-side
//             valid/ready path of the output port buffer.
//  Signals  : wr_en, wr_data, stall        - core writeback side
//             out_valid, out_ready,
//             out_data, out_port, count    - consumer / status side
//  Modports : slave  - the buffer itself
//             master - the environment driving it (core + consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface out_port_buffer_if #(
    parameter int WIDTH  = cpu_pkg::WORD_W,
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              stall;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [WIDTH-1:0]  out_port;
    logic [ADDR_W:0]   count;

    modport slave (
        input  wr_en,
        input  wr_data,
        output stall,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_port,
        output count
    );

    modport master (
        output wr_en,
        output wr_data,
        input  stall,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_port,
        input  count
    );

endinterface
`default_nettype wire

// File: rtl/out_port_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Generic single-clock FIFO: storage array, wrapping read/write
//             pointers and an occupancy counter that tells full from empty.
//  Ports    : clk, rst           - clock, async active-high reset
//             push_i, push_data_i - write strobe / data (caller never pushes
//                                   while full)
//             pop_i               - read strobe (caller never pops while empty)
//             head_o              - word at the read pointer (raw storage)
//             full_o, empty_o     - occupancy flags
//             count_o             - occupied entries, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push_i,
    input  wire logic [WIDTH-1:0]  push_data_i,
    input  wire logic              pop_i,
    output logic      [WIDTH-1:0]  head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic      [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W:0] c_FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;

    // Pointers are exactly log2(DEPTH) bits, so +1 wraps DEPTH-1 -> 0 for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; count==0 masks stale words.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == c_FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= c_FULL_CNT);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop_i && empty_o));

endmodule
`default_nettype wire

// File: rtl/out_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_buffer
//  Purpose  : Decouples OUT-instruction writes from a slow external consumer.
//             Writes are queued in a small FIFO and drained over valid/ready;
//             the last delivered word is held on out_port so the pin-level
//             behaviour of the original out_port is preserved.
//  Ports    : clk, rst  - clock, async active-high reset
//             bus       - out_port_buffer_if.slave:
//                           wr_en/wr_data/stall        core writeback side
//                           out_valid/out_ready/out_data consumer handshake
//                           out_port                     held last word
//                           count                        occupancy 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module out_port_buffer
    import cpu_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    out_port_buffer_if.slave   bus
);

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [WIDTH-1:0]  w_head;
    logic [ADDR_W:0]   w_count;
    logic [WIDTH-1:0]  out_port_q, out_port_d;

    // A pop in the same cycle does not make room for a write when full:
    // full comes from registered count only, so there is no write-through.
    assign w_push = bus.wr_en && !w_full;
    assign w_pop  = !w_empty && bus.out_ready;

    sync_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (bus.wr_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    always_comb begin
        out_port_d = out_port_q;
        if (w_pop) begin
            out_port_d = w_head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port_q <= '0;
        end else begin
            out_port_q <= out_port_d;
        end
    end

    assign bus.stall     = bus.wr_en && w_full;
    assign bus.out_valid = !w_empty;
    // Mask unreset storage so an empty FIFO always presents zero.
    assign bus.out_data  = w_empty ? '0 : w_head;
    assign bus.out_port  = out_port_q;
    assign bus.count     = w_count;

endmodule
`default_nettype wire
